// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions.
// ALU op codes, forwarding selects, branch funct3 and the EX/MEM bundle.
package rv32i_pkg;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_SLL   = 4'h2;
  localparam logic [3:0] ALU_SLT   = 4'h3;
  localparam logic [3:0] ALU_SLTU  = 4'h4;
  localparam logic [3:0] ALU_XOR   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_OR    = 4'h8;
  localparam logic [3:0] ALU_AND   = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;

  localparam logic [1:0] FWD_RD  = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_RD2 = 2'b11;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_IMM = 3'd3;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [4:0]  rd;
  } ex_mem_t;

endpackage

// File: rtl/alu_rv32i.sv
// Combinational RV32I ALU.
// Undefined op codes fall back to ADD.
module alu_rv32i
  import rv32i_pkg::*;
(
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = a + b;
    case (alu_op)
      ALU_SUB:   y = a - b;
      ALU_SLL:   y = a << shamt;
      ALU_SLT:   y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {31'd0, a < b};
      ALU_XOR:   y = a ^ b;
      ALU_SRL:   y = a >> shamt;
      ALU_SRA:   y = $unsigned($signed(a) >>> shamt);
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_PASSB: y = b;
      default:   y = a + b;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// RV32I execute stage with the EX/MEM pipeline register.
// Forwarding, ALU, branch/jump resolution, M-stage control registration.
module ex_mem_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            StallM,
  input  logic            FlushM,
  input  logic            MemReadE,
  input  logic            MemWriteE,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            MuxjalrE,
  input  logic [3:0]      ALUOpE,
  input  logic [2:0]      WriteBackE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      Rs1E,
  input  logic [4:0]      Rs2E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            MemReadM,
  output logic [2:0]      WriteBackM,
  output logic [2:0]      funct3M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] ImmExtM,
  output logic [4:0]      RdM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_y;
  logic            br_cond;
  ex_mem_t         mem_d;
  ex_mem_t         mem_q;
  logic            unused_rs;

  assign unused_rs = ^{Rs1E, Rs2E};

  // ALUResultM here is the pre-edge register value
  always_comb begin
    case (ForwardAE)
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      FWD_W:   fwd_b = ResultW;
      FWD_M:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : fwd_b;

  alu_rv32i u_alu (
    .alu_op (ALUOpE),
    .a      (src_a),
    .b      (src_b),
    .y      (alu_y)
  );

  always_comb begin
    br_cond = 1'b0;
    case (funct3E)
      BR_EQ:   br_cond = src_a == fwd_b;
      BR_NE:   br_cond = src_a != fwd_b;
      BR_LT:   br_cond = $signed(src_a) < $signed(fwd_b);
      BR_GE:   br_cond = $signed(src_a) >= $signed(fwd_b);
      BR_LTU:  br_cond = src_a < fwd_b;
      BR_GEU:  br_cond = src_a >= fwd_b;
      default: br_cond = 1'b0;
    endcase
  end

  assign PCTargetE = MuxjalrE ? ((src_a + ImmExtE) & ~32'h1)
                              : (PCE + ImmExtE);
  assign PCSrcE = ~StallE & (JumpE | (BranchE & br_cond));

  always_comb begin
    mem_d = mem_q;
    if (FlushM) begin
      mem_d = '0;
    end else if (StallM) begin
      mem_d = mem_q;
    end else if (StallE) begin
      mem_d = '0;
    end else begin
      mem_d.reg_write  = RegWriteE;
      mem_d.mem_write  = MemWriteE;
      mem_d.mem_read   = MemReadE;
      mem_d.wb_sel     = WriteBackE;
      mem_d.funct3     = funct3E;
      mem_d.alu_result = alu_y;
      mem_d.write_data = fwd_b;
      mem_d.pc_plus4   = PCPlus4E;
      mem_d.imm_ext    = ImmExtE;
      mem_d.rd         = RdE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign RegWriteM  = mem_q.reg_write;
  assign MemWriteM  = mem_q.mem_write;
  assign MemReadM   = mem_q.mem_read;
  assign WriteBackM = mem_q.wb_sel;
  assign funct3M    = mem_q.funct3;
  assign ALUResultM = mem_q.alu_result;
  assign WriteDataM = mem_q.write_data;
  assign PCPlus4M   = mem_q.pc_plus4;
  assign ImmExtM    = mem_q.imm_ext;
  assign RdM        = mem_q.rd;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage.
// Expected M bundles are queued when driven and popped after each edge.
module tb_ex_mem_stage;

  typedef struct {
    logic        rw, mw, mr;
    logic [2:0]  wb, f3;
    logic [31:0] alu, wd, pc4, imm;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic StallE, StallM, FlushM;
  logic MemReadE, MemWriteE, RegWriteE, ALUSrcE;
  logic JumpE, BranchE, MuxjalrE;
  logic [3:0] ALUOpE;
  logic [2:0] WriteBackE, funct3E;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic PCSrcE;
  logic [31:0] PCTargetE;
  logic RegWriteM, MemWriteM, MemReadM;
  logic [2:0] WriteBackM, funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, ImmExtM;
  logic [4:0] RdM;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  exp_t m_exp;
  exp_t zero_e;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset),
    .StallE(StallE), .StallM(StallM), .FlushM(FlushM),
    .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
    .JumpE(JumpE), .BranchE(BranchE), .MuxjalrE(MuxjalrE),
    .ALUOpE(ALUOpE), .WriteBackE(WriteBackE), .funct3E(funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .MemReadM(MemReadM), .WriteBackM(WriteBackM),
    .funct3M(funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .ImmExtM(ImmExtM), .RdM(RdM)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input exp_t e);
    chk({tag, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, e.rw});
    chk({tag, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, e.mw});
    chk({tag, ".MemReadM"}, {31'd0, MemReadM}, {31'd0, e.mr});
    chk({tag, ".WriteBackM"}, {29'd0, WriteBackM}, {29'd0, e.wb});
    chk({tag, ".funct3M"}, {29'd0, funct3M}, {29'd0, e.f3});
    chk({tag, ".ALUResultM"}, ALUResultM, e.alu);
    chk({tag, ".WriteDataM"}, WriteDataM, e.wd);
    chk({tag, ".PCPlus4M"}, PCPlus4M, e.pc4);
    chk({tag, ".ImmExtM"}, ImmExtM, e.imm);
    chk({tag, ".RdM"}, {27'd0, RdM}, {27'd0, e.rd});
  endtask

  function automatic logic [31:0] ref_fwd_b();
    if (ForwardBE == 2'b01) return ResultW;
    if (ForwardBE == 2'b10) return m_exp.alu;
    return RD2E;
  endfunction

  task automatic push_load(input logic [31:0] exp_alu);
    exp_t e;
    e.rw  = RegWriteE;
    e.mw  = MemWriteE;
    e.mr  = MemReadE;
    e.wb  = WriteBackE;
    e.f3  = funct3E;
    e.alu = exp_alu;
    e.wd  = ref_fwd_b();
    e.pc4 = PCPlus4E;
    e.imm = ImmExtE;
    e.rd  = RdE;
    sbq.push_back(e);
    m_exp = e;
  endtask

  task automatic push_exp(input exp_t e);
    sbq.push_back(e);
    m_exp = e;
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sbq.size() != 0) else begin
      errors++;
      $error("FAIL %s.sb obs=empty exp=entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk_m(tag, e);
    end
  endtask

  task automatic clr_in();
    StallE = 0; StallM = 0; FlushM = 0;
    MemReadE = 0; MemWriteE = 0; RegWriteE = 0;
    ALUSrcE = 0; JumpE = 0; BranchE = 0; MuxjalrE = 0;
    ALUOpE = 4'h0; WriteBackE = 3'd0; funct3E = 3'd0;
    RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0;
    Rs1E = 0; Rs2E = 0; RdE = 0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 0;
  endtask

  initial begin
    zero_e = '{default: '0};
    m_exp = zero_e;
    clr_in();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_m("reset", zero_e);
    reset = 0;

    // ADD with ResultW forwarded on A
    RD1E = 5; ResultW = 7; ForwardAE = 2'b01; RD2E = 3;
    RegWriteE = 1; RdE = 5'd3; PCPlus4E = 32'h104;
    ImmExtE = 32'h11; WriteBackE = 3'd2; funct3E = 3'b010;
    push_load(32'd10);
    step("add_fwd");

    clr_in();
    RD1E = 32'h8000_0000; ALUSrcE = 1; ImmExtE = 4;
    ALUOpE = 4'h7; RD2E = 32'hAA; RdE = 5'd7; RegWriteE = 1;
    push_load(32'hF800_0000);
    step("sra");

    clr_in();
    RD1E = 1; RD2E = 32'hFFFF_FFFF; ALUOpE = 4'h4;
    MemWriteE = 1; funct3E = 3'b001;
    push_load(32'd1);
    step("sltu");

    // Forward previous ALUResultM (1) on A and B
    clr_in();
    ForwardAE = 2'b10; ForwardBE = 2'b10; RD1E = 32'hDEAD;
    ALUSrcE = 1; ImmExtE = 5; MemReadE = 1; RdE = 5'd9;
    push_load(32'd6);
    step("fwd_m");

    clr_in();
    ALUOpE = 4'hA; ALUSrcE = 1; ImmExtE = 32'h1234_5000;
    RD1E = 32'h55; RegWriteE = 1; RdE = 5'd0; WriteBackE = 3'd3;
    push_load(32'h1234_5000);
    step("lui_rd0");

    clr_in();
    RD1E = 3; RD2E = 5; ALUOpE = 4'h1;
    push_load(32'hFFFF_FFFE);
    step("sub");

    clr_in();
    RD1E = 2; RD2E = 3; ALUOpE = 4'hF;
    push_load(32'd5);
    step("op_f_add");

    // Branch resolution is combinational
    clr_in();
    RD1E = 32'hFFFF_FFFF; RD2E = 1; funct3E = 3'b100;
    BranchE = 1; PCE = 32'h100; ImmExtE = 32'h20;
    #1;
    chk("blt.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    chk("blt.PCTargetE", PCTargetE, 32'h120);
    funct3E = 3'b101; #1;
    chk("bge.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    funct3E = 3'b110; #1;
    chk("bltu.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    funct3E = 3'b111; #1;
    chk("bgeu.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    funct3E = 3'b010; #1;
    chk("f3_010.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    funct3E = 3'b000; RD2E = 32'hFFFF_FFFF; #1;
    chk("beq.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    push_load(32'hFFFF_FFFE);
    step("branch_m");

    clr_in();
    RD1E = 32'h1003; ImmExtE = 4; MuxjalrE = 1; JumpE = 1;
    ALUSrcE = 1; RegWriteE = 1; RdE = 5'd1; PCE = 32'h400;
    PCPlus4E = 32'h404; WriteBackE = 3'd2;
    #1;
    chk("jalr.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    chk("jalr.PCTargetE", PCTargetE, 32'h1006);
    StallE = 1; #1;
    chk("jalr_stall.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    push_exp(zero_e);
    step("stall_e");
    StallE = 0;
    push_load(32'h1007);
    step("jalr_load");

    // StallM holds two cycles, then FlushM clears
    RD1E = 32'h99; RdE = 5'd20; StallM = 1;
    push_exp(m_exp);
    step("stallm1");
    push_exp(m_exp);
    step("stallm2");
    StallM = 0; FlushM = 1;
    push_exp(zero_e);
    step("flushm");

    clr_in();
    RD1E = 2; RD2E = 3; RegWriteE = 1; MemWriteE = 1; RdE = 5'd4;
    push_load(32'd5);
    step("reload");
    FlushM = 1; StallM = 1;
    push_exp(zero_e);
    step("flush_stall");

    clr_in();
    RD1E = 40; RD2E = 2; RegWriteE = 1; RdE = 5'd12;
    push_load(32'd42);
    step("pre_reset");

    // Asynchronous reset between edges
    #2;
    reset = 1;
    #1;
    chk("async.RegWriteM", {31'd0, RegWriteM}, 32'd0);
    chk("async.ALUResultM", ALUResultM, 32'd0);
    m_exp = zero_e;
    StallM = 1;
    @(posedge clk);
    #1;
    chk_m("reset_hold", zero_e);
    StallM = 0;
    reset = 0;
    RD1E = 8; RD2E = 1; ALUOpE = 4'h2;
    push_load(32'd16);
    step("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
